ix_execute_stage: RTL and testbench

- Execute (IX) stage. Consumes the decoded operands and controls latched by the ID/IX pipeline register. Drives the IX/MEM register and redirects fetch.
- Single-cycle combinational ALU, branch/jump resolution, and an iterative multiply/divide unit writing internal HI/LO registers.
- Stalls upstream while a dependent HI/LO or MD op waits for the MD unit.

---
 rtl/ix_execute_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_ix_execute_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ix_execute_stage.sv
// Execute stage: single-cycle ALU, branch/jump resolution and an iterative MUL/DIV unit owning HI/LO.
// Optional build macro IX_OVERFLOW_TRAP_EN: signed ADD/SUB overflow raises overflow_out and kills writeback.
//
//   state    | meaning
//   MD_IDLE  | no MD op in flight; HI/LO readable
//   MD_BUSY  | retiring BITS_PER_CYCLE bits per cycle for 32/BITS_PER_CYCLE cycles
//   MD_FIXUP | apply result signs and write HI/LO
module ix_execute_stage #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] ir_in,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic [5:0]  alu_op_in,
    input  logic        op2_sel_in,
    input  logic [5:0]  shift_amount_in,
    input  logic        is_branch_in,
    input  logic        is_jump_in,
    input  logic [1:0]  branch_type_in,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic        valid_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_target_out,
    output logic        stall_out,
    output logic        md_busy_out,
    output logic        overflow_out
);
    localparam int          N      = 32 / BITS_PER_CYCLE;
    localparam logic [5:0]  N_LAST = 6'(N - 1);

    localparam logic [5:0] OP_SLL  = 6'h00, OP_SRL  = 6'h02, OP_SRA  = 6'h03;
    localparam logic [5:0] OP_SLLV = 6'h04, OP_SRLV = 6'h06, OP_SRAV = 6'h07;
    localparam logic [5:0] OP_JR   = 6'h08, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_MFHI = 6'h10, OP_MFLO = 6'h12;
    localparam logic [5:0] OP_MULT = 6'h18, OP_MULTU = 6'h19, OP_DIV = 6'h1A, OP_DIVU = 6'h1B;
    localparam logic [5:0] OP_ADD  = 6'h20, OP_ADDU = 6'h21, OP_SUB = 6'h22, OP_SUBU = 6'h23;
    localparam logic [5:0] OP_AND  = 6'h24, OP_OR   = 6'h25, OP_XOR = 6'h26, OP_NOR  = 6'h27;
    localparam logic [5:0] OP_SLT  = 6'h2A, OP_SLTU = 6'h2B;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_FIXUP} md_state_t;

    md_state_t   state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] md_hi_q, md_lo_q, md_opnd_q;
    logic        md_is_div_q, md_neg_q, md_rem_neg_q, md_div_zero_q;

    logic [31:0] imm_sext, op2, pc_plus4, pc_plus8, sum, diff, alu_res;
    logic [4:0]  shamt;
    logic        add_ovf, sub_ovf, ovf_trap, branch_cond;
    logic        is_md_op, is_hilo_read, md_start, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] step_hi, step_lo, fix_hi, fix_lo;
    logic [32:0] div_rem, mul_sum;
    logic [63:0] prod;
    logic        unused_ok;

    assign imm_sext = {{16{ir_in[15]}}, ir_in[15:0]};
    assign op2      = op2_sel_in ? imm_sext : B_in;
    assign pc_plus4 = pc_in + 32'd4;
    assign pc_plus8 = pc_in + 32'd8;
    assign sum      = A_in + op2;
    assign diff     = A_in - op2;
    assign add_ovf  = (A_in[31] == op2[31]) && (sum[31] != A_in[31]);
    assign sub_ovf  = (A_in[31] != op2[31]) && (diff[31] != A_in[31]);
    assign shamt    = (alu_op_in == OP_SLLV || alu_op_in == OP_SRLV || alu_op_in == OP_SRAV)
                      ? A_in[4:0] : shift_amount_in[4:0];
    assign unused_ok = ^{ir_in[31:26], shift_amount_in[5], add_ovf, sub_ovf};

    always_comb begin
        alu_res = 32'd0;
        case (alu_op_in)
            OP_ADD, OP_ADDU: alu_res = sum;
            OP_SUB, OP_SUBU: alu_res = diff;
            OP_AND:          alu_res = A_in & op2;
            OP_OR:           alu_res = A_in | op2;
            OP_XOR:          alu_res = A_in ^ op2;
            OP_NOR:          alu_res = ~(A_in | op2);
            OP_SLT:          alu_res = {31'd0, $signed(A_in) < $signed(op2)};
            OP_SLTU:         alu_res = {31'd0, A_in < op2};
            OP_LUI:          alu_res = {op2[15:0], 16'd0};
            OP_SLL, OP_SLLV: alu_res = B_in << shamt;
            OP_SRL, OP_SRLV: alu_res = B_in >> shamt;
            OP_SRA, OP_SRAV: alu_res = $signed(B_in) >>> shamt;
            OP_MFHI:         alu_res = hi_q;
            OP_MFLO:         alu_res = lo_q;
            default:         alu_res = 32'd0;
        endcase
    end

    assign is_md_op     = (alu_op_in == OP_MULT) || (alu_op_in == OP_MULTU) ||
                          (alu_op_in == OP_DIV)  || (alu_op_in == OP_DIVU);
    assign is_hilo_read = (alu_op_in == OP_MFHI) || (alu_op_in == OP_MFLO);

`ifdef IX_OVERFLOW_TRAP_EN
    assign ovf_trap     = valid_in && ((alu_op_in == OP_ADD && add_ovf) || (alu_op_in == OP_SUB && sub_ovf));
    assign overflow_out = ~rst & ovf_trap;
`else
    assign ovf_trap     = 1'b0;
    assign overflow_out = 1'b0;
`endif

    assign stall_out   = ~rst & valid_in & (is_md_op | is_hilo_read) & (state_q != MD_IDLE);
    assign valid_out   = valid_in & ~stall_out & ~rst & ~ovf_trap;
    assign md_busy_out = ~rst & (state_q != MD_IDLE);
    assign store_data_out = B_in;

    always_comb begin
        branch_cond = 1'b0;
        case (branch_type_in)
            2'b00: branch_cond = (A_in == B_in);
            2'b01: branch_cond = (A_in != B_in);
            2'b10: branch_cond = ($signed(A_in) <= 0);
            2'b11: branch_cond = ($signed(A_in) > 0);
            default: branch_cond = 1'b0;
        endcase
    end

    assign branch_taken_out  = valid_out & (is_jump_in | (is_branch_in & branch_cond));
    assign branch_target_out = !is_jump_in           ? pc_plus4 + {imm_sext[29:0], 2'b00} :
                               (alu_op_in == OP_JR)  ? A_in :
                                                       {pc_plus4[31:28], ir_in[25:0], 2'b00};
    assign alu_result_out    = is_jump_in ? pc_plus8 : alu_res;

    // MD operands are latched as magnitudes; signs are reapplied in FIXUP
    assign md_start = valid_out & is_md_op & (state_q == MD_IDLE);
    assign a_neg    = ((alu_op_in == OP_MULT) || (alu_op_in == OP_DIV)) && A_in[31];
    assign b_neg    = ((alu_op_in == OP_MULT) || (alu_op_in == OP_DIV)) && B_in[31];
    assign a_mag    = a_neg ? (32'd0 - A_in) : A_in;
    assign b_mag    = b_neg ? (32'd0 - B_in) : B_in;

    // Shift-add multiply keeps {partial product, multiplier} in {md_hi, md_lo};
    // restoring divide keeps {remainder, dividend/quotient} in the same pair.
    always_comb begin
        step_hi = md_hi_q;
        step_lo = md_lo_q;
        div_rem = 33'd0;
        mul_sum = 33'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (md_is_div_q) begin
                div_rem = {step_hi, step_lo[31]};
                step_lo = {step_lo[30:0], 1'b0};
                if (div_rem >= {1'b0, md_opnd_q}) begin
                    div_rem    = div_rem - {1'b0, md_opnd_q};
                    step_lo[0] = 1'b1;
                end
                step_hi = div_rem[31:0];
            end else begin
                mul_sum = {1'b0, step_hi} + (step_lo[0] ? {1'b0, md_opnd_q} : 33'd0);
                {step_hi, step_lo} = {mul_sum, step_lo[31:1]};
            end
        end
    end

    always_comb begin
        prod   = {md_hi_q, md_lo_q};
        fix_hi = md_hi_q;
        fix_lo = md_lo_q;
        if (md_is_div_q) begin
            fix_lo = md_div_zero_q ? 32'hFFFF_FFFF : (md_neg_q ? (32'd0 - md_lo_q) : md_lo_q);
            fix_hi = md_rem_neg_q ? (32'd0 - md_hi_q) : md_hi_q;
        end else if (md_neg_q) begin
            {fix_hi, fix_lo} = 64'd0 - prod;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE:  if (md_start) state_d = MD_BUSY;
            MD_BUSY:  if (cnt_q == N_LAST) state_d = MD_FIXUP;
            MD_FIXUP: state_d = MD_IDLE;
            default:  state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            md_hi_q       <= '0;
            md_lo_q       <= '0;
            md_opnd_q     <= '0;
            md_is_div_q   <= 1'b0;
            md_neg_q      <= 1'b0;
            md_rem_neg_q  <= 1'b0;
            md_div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start) begin
                        cnt_q         <= '0;
                        md_hi_q       <= '0;
                        md_lo_q       <= a_mag;
                        md_opnd_q     <= b_mag;
                        md_is_div_q   <= (alu_op_in == OP_DIV) || (alu_op_in == OP_DIVU);
                        md_neg_q      <= a_neg ^ b_neg;
                        md_rem_neg_q  <= a_neg;
                        md_div_zero_q <= (B_in == 32'd0);
                    end
                end
                MD_BUSY: begin
                    md_hi_q <= step_hi;
                    md_lo_q <= step_lo;
                    cnt_q   <= cnt_q + 6'd1;
                end
                MD_FIXUP: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ix_execute_stage.sv
// Directed bench for ix_execute_stage: expected values go through a scoreboard queue and are
// compared with immediate assertions when the DUT output is sampled.
module tb_ix_execute_stage;
    localparam int BPC = 1;
    localparam int N   = 32 / BPC;

    localparam logic [5:0] OP_SLL = 6'h00, OP_SRL = 6'h02, OP_SRA = 6'h03, OP_SLLV = 6'h04;
    localparam logic [5:0] OP_SRLV = 6'h06, OP_SRAV = 6'h07, OP_JR = 6'h08, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_MFHI = 6'h10, OP_MFLO = 6'h12;
    localparam logic [5:0] OP_MULT = 6'h18, OP_MULTU = 6'h19, OP_DIV = 6'h1A, OP_DIVU = 6'h1B;
    localparam logic [5:0] OP_ADD = 6'h20, OP_ADDU = 6'h21, OP_SUB = 6'h22, OP_SUBU = 6'h23;
    localparam logic [5:0] OP_AND = 6'h24, OP_OR = 6'h25, OP_XOR = 6'h26, OP_NOR = 6'h27;
    localparam logic [5:0] OP_SLT = 6'h2A, OP_SLTU = 6'h2B, OP_BAD = 6'h3F;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] pc_in, ir_in, A_in, B_in;
    logic [5:0]  alu_op_in, shift_amount_in;
    logic        op2_sel_in, is_branch_in, is_jump_in;
    logic [1:0]  branch_type_in;
    logic [31:0] alu_result_out, store_data_out, branch_target_out;
    logic        valid_out, branch_taken_out, stall_out, md_busy_out, overflow_out;

    always #5 clk = ~clk;

    ix_execute_stage #(.BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .ir_in(ir_in),
        .A_in(A_in), .B_in(B_in), .alu_op_in(alu_op_in), .op2_sel_in(op2_sel_in),
        .shift_amount_in(shift_amount_in), .is_branch_in(is_branch_in), .is_jump_in(is_jump_in),
        .branch_type_in(branch_type_in), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .valid_out(valid_out), .branch_taken_out(branch_taken_out),
        .branch_target_out(branch_target_out), .stall_out(stall_out), .md_busy_out(md_busy_out),
        .overflow_out(overflow_out)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ir;
        logic        sel;
        logic [5:0]  sh;
        logic [31:0] res;
        string       name;
    } alu_vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    alu_vec_t    alu_tab[$];

    task automatic put(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h but no expected value queued", tag, obs);
        end else begin
            exp_v = sb_q.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ir, input logic sel, input logic [5:0] sh,
                       input logic br, input logic jp, input logic [1:0] bt, input logic [31:0] pc);
        valid_in = v; alu_op_in = op; A_in = a; B_in = b; ir_in = ir; op2_sel_in = sel;
        shift_amount_in = sh; is_branch_in = br; is_jump_in = jp; branch_type_in = bt; pc_in = pc;
    endtask

    task automatic drv_op(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        drv(v, op, a, b, 32'd0, 1'b0, 6'd0, 1'b0, 1'b0, 2'b00, 32'h0040_0000);
    endtask

    task automatic md_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
        logic signed [63:0] sp;
        logic [63:0]        up;
        hi = 32'd0; lo = 32'd0;
        if (op == OP_MULT) begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            hi = sp[63:32]; lo = sp[31:0];
        end else if (op == OP_MULTU) begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32]; lo = up[31:0];
        end else if (b == 32'd0) begin
            hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000; hi = 32'd0;
            end else begin
                lo = $signed(a) / $signed(b);
                hi = $signed(a) % $signed(b);
            end
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        drv_op(1'b0, OP_ADDU, 32'd0, 32'd0);
        smp();
        while (md_busy_out !== 1'b0 && n < 200) begin
            cyc();
            smp();
            n++;
        end
        put(32'd0);
        chk(tag, {31'd0, md_busy_out});
    endtask

    task automatic run_md(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi, lo;
        md_model(op, a, b, hi, lo);
        drv_op(1'b1, op, a, b);
        smp();
        put(32'd0); chk({tag, "_issue_stall"}, {31'd0, stall_out});
        cyc();
        wait_idle({tag, "_done"});
        cyc();
        drv_op(1'b1, OP_MFLO, 32'd0, 32'd0);
        smp();
        put(lo); chk({tag, "_lo"}, alu_result_out);
        cyc();
        drv_op(1'b1, OP_MFHI, 32'd0, 32'd0);
        smp();
        put(hi); chk({tag, "_hi"}, alu_result_out);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hi, lo;
        logic        exp_trap;
        int          n;
`ifdef IX_OVERFLOW_TRAP_EN
        exp_trap = 1'b1;
`else
        exp_trap = 1'b0;
`endif
        rst = 1'b1;
        drv_op(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
        smp();
        put(32'd0); chk("rst_valid_out", {31'd0, valid_out});
        put(32'd0); chk("rst_overflow", {31'd0, overflow_out});
        put(32'd0); chk("rst_stall", {31'd0, stall_out});
        put(32'd0); chk("rst_md_busy", {31'd0, md_busy_out});
        cyc();
        cyc();
        rst = 1'b0;

        drv_op(1'b1, OP_MFHI, 32'd0, 32'd0);
        smp();
        put(32'd0); chk("post_rst_mfhi", alu_result_out);
        put(32'd1); chk("post_rst_valid", {31'd0, valid_out});
        cyc();

        alu_tab.push_back('{OP_ADDU, 32'd5,          32'd3,          32'h0,      1'b0, 6'd0, 32'd8,          "addu"});
        alu_tab.push_back('{OP_ADDU, 32'd10,         32'd0,          32'h0000_FFFF, 1'b1, 6'd0, 32'd9,       "addiu_neg"});
        alu_tab.push_back('{OP_ADD,  32'd2,          32'd3,          32'h0,      1'b0, 6'd0, 32'd5,          "add"});
        alu_tab.push_back('{OP_SUB,  32'd2,          32'd3,          32'h0,      1'b0, 6'd0, 32'hFFFF_FFFF,  "sub"});
        alu_tab.push_back('{OP_SUBU, 32'd3,          32'd5,          32'h0,      1'b0, 6'd0, 32'hFFFF_FFFE,  "subu"});
        alu_tab.push_back('{OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0,      1'b0, 6'd0, 32'hF000_F000,  "and"});
        alu_tab.push_back('{OP_OR,   32'hF0F0_F0F0,  32'h0F0F_0000,  32'h0,      1'b0, 6'd0, 32'hFFFF_F0F0,  "or"});
        alu_tab.push_back('{OP_XOR,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'h0,      1'b0, 6'd0, 32'hF0F0_0F0F,  "xor"});
        alu_tab.push_back('{OP_NOR,  32'hF0F0_F0F0,  32'h0F0F_0000,  32'h0,      1'b0, 6'd0, 32'h0000_0F0F,  "nor"});
        alu_tab.push_back('{OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'h0,      1'b0, 6'd0, 32'd1,          "slt"});
        alu_tab.push_back('{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'h0,      1'b0, 6'd0, 32'd0,          "sltu"});
        alu_tab.push_back('{OP_LUI,  32'd0,          32'd0,          32'h0000_1234, 1'b1, 6'd0, 32'h1234_0000, "lui"});
        alu_tab.push_back('{OP_SLL,  32'd0,          32'd1,          32'h0,      1'b0, 6'd4, 32'h0000_0010,  "sll"});
        alu_tab.push_back('{OP_SRL,  32'd0,          32'h8000_0000,  32'h0,      1'b0, 6'd4, 32'h0800_0000,  "srl"});
        alu_tab.push_back('{OP_SRA,  32'd0,          32'h8000_0000,  32'h0,      1'b0, 6'd4, 32'hF800_0000,  "sra"});
        alu_tab.push_back('{OP_SLLV, 32'd8,          32'd3,          32'h0,      1'b0, 6'd0, 32'h0000_0300,  "sllv"});
        alu_tab.push_back('{OP_SRLV, 32'd1,          32'hFFFF_FFFF,  32'h0,      1'b0, 6'd0, 32'h7FFF_FFFF,  "srlv"});
        alu_tab.push_back('{OP_SRAV, 32'h24,         32'hF000_0000,  32'h0,      1'b0, 6'd9, 32'hFF00_0000,  "srav"});
        alu_tab.push_back('{OP_BAD,  32'd5,          32'd3,          32'h0,      1'b0, 6'd0, 32'd0,          "unknown"});
        foreach (alu_tab[i]) begin
            drv(1'b1, alu_tab[i].op, alu_tab[i].a, alu_tab[i].b, alu_tab[i].ir, alu_tab[i].sel,
                alu_tab[i].sh, 1'b0, 1'b0, 2'b00, 32'h0040_0000);
            smp();
            put(alu_tab[i].res); chk(alu_tab[i].name, alu_result_out);
            put(32'd1);          chk({alu_tab[i].name, "_valid"}, {31'd0, valid_out});
            put(alu_tab[i].b);   chk({alu_tab[i].name, "_store"}, store_data_out);
            cyc();
        end

        drv_op(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
        smp();
        put(32'h8000_0000);     chk("add_ovf_result", alu_result_out);
        put({31'd0, exp_trap}); chk("add_ovf_flag", {31'd0, overflow_out});
        put({31'd0, ~exp_trap}); chk("add_ovf_valid", {31'd0, valid_out});
        cyc();
        drv_op(1'b1, OP_SUB, 32'h8000_0000, 32'd1);
        smp();
        put({31'd0, exp_trap}); chk("sub_ovf_flag", {31'd0, overflow_out});
        cyc();
        drv_op(1'b1, OP_SUBU, 32'h8000_0000, 32'd1);
        smp();
        put(32'h7FFF_FFFF); chk("subu_wrap", alu_result_out);
        put(32'd0);         chk("subu_no_trap", {31'd0, overflow_out});
        put(32'd1);         chk("subu_valid", {31'd0, valid_out});
        cyc();
        drv_op(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'd1);
        smp();
        put(32'd0); chk("add_ovf_bubble", {31'd0, overflow_out});
        cyc();

        drv(1'b1, OP_SUBU, 32'd1, 32'd2, 32'h0000_FFFE, 1'b0, 6'd0, 1'b1, 1'b0, 2'b01, 32'h0040_0000);
        smp();
        put(32'd1);         chk("bne_taken", {31'd0, branch_taken_out});
        put(32'h003F_FFFC); chk("bne_target", branch_target_out);
        cyc();
        valid_in = 1'b0;
        smp();
        put(32'd0); chk("bne_bubble", {31'd0, branch_taken_out});
        cyc();
        drv(1'b1, OP_SUBU, 32'd1, 32'd2, 32'h0000_0010, 1'b0, 6'd0, 1'b1, 1'b0, 2'b00, 32'h0040_0000);
        smp();
        put(32'd0); chk("beq_not_taken", {31'd0, branch_taken_out});
        cyc();
        drv(1'b1, OP_SUBU, 32'd0, 32'd5, 32'h0000_0010, 1'b0, 6'd0, 1'b1, 1'b0, 2'b10, 32'h0040_0000);
        smp();
        put(32'd1);         chk("blez_zero_taken", {31'd0, branch_taken_out});
        put(32'h0040_0044); chk("blez_target", branch_target_out);
        cyc();
        drv(1'b1, OP_SUBU, 32'h8000_0000, 32'd0, 32'h0000_0010, 1'b0, 6'd0, 1'b1, 1'b0, 2'b11, 32'h0040_0000);
        smp();
        put(32'd0); chk("bgtz_neg_not_taken", {31'd0, branch_taken_out});
        cyc();
        drv(1'b1, OP_BAD, 32'd0, 32'd0, 32'h0810_0000, 1'b0, 6'd0, 1'b0, 1'b1, 2'b00, 32'h1000_0000);
        smp();
        put(32'd1);         chk("j_taken", {31'd0, branch_taken_out});
        put(32'h1040_0000); chk("j_target", branch_target_out);
        put(32'h1000_0008); chk("j_link", alu_result_out);
        cyc();
        drv(1'b1, OP_JR, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b1, 2'b00, 32'h0040_0010);
        smp();
        put(32'h0000_1234); chk("jr_target", branch_target_out);
        put(32'h0040_0018); chk("jr_link", alu_result_out);
        cyc();

        md_model(OP_MULT, 32'hFFFF_FFFD, 32'd5, hi, lo);
        drv_op(1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd5);
        smp();
        put(32'd1); chk("mult_issue_valid", {31'd0, valid_out});
        cyc();
        drv_op(1'b1, OP_MFLO, 32'd0, 32'd0);
        smp();
        put(32'd1); chk("mflo_stalled", {31'd0, stall_out});
        put(32'd0); chk("mflo_stalled_valid", {31'd0, valid_out});
        n = 0;
        while (stall_out === 1'b1 && n < 200) begin
            n++;
            cyc();
            smp();
        end
        put(32'(N + 1));   chk("mult_stall_cycles", 32'(n));
        put(32'hFFFF_FFF1); chk("mult_lo_const", lo);
        put(lo);           chk("mult_mflo", alu_result_out);
        cyc();
        drv_op(1'b1, OP_MFHI, 32'd0, 32'd0);
        smp();
        put(hi); chk("mult_mfhi", alu_result_out);
        cyc();

        md_model(OP_DIV, 32'hFFFF_FFF9, 32'd2, hi, lo);
        drv_op(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        smp();
        cyc();
        drv_op(1'b1, OP_ADDU, 32'd1, 32'd2);
        smp();
        put(32'd0); chk("busy_add_stall", {31'd0, stall_out});
        put(32'd1); chk("busy_add_valid", {31'd0, valid_out});
        put(32'd3); chk("busy_add_result", alu_result_out);
        put(32'd1); chk("busy_md_busy", {31'd0, md_busy_out});
        cyc();
        wait_idle("div_done");
        cyc();
        drv_op(1'b1, OP_MFLO, 32'd0, 32'd0);
        smp();
        put(lo); chk("div_lo", alu_result_out);
        cyc();
        drv_op(1'b1, OP_MFHI, 32'd0, 32'd0);
        smp();
        put(hi); chk("div_hi", alu_result_out);
        cyc();

        run_md("divu_by_zero", OP_DIVU, 32'h1234_5678, 32'd0);
        run_md("div_by_zero",  OP_DIV,  32'hFFFF_FFF9, 32'd0);
        run_md("div_minint",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_md("div_pos_neg",  OP_DIV,  32'd7,         32'hFFFF_FFFE);
        run_md("divu_big",     OP_DIVU, 32'hFFFF_FFF0, 32'd7);
        run_md("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("mult_minint",  OP_MULT, 32'h8000_0000, 32'h8000_0000);

        drv_op(1'b1, OP_MULT, 32'd3, 32'd5);
        smp();
        cyc();
        drv_op(1'b0, OP_ADDU, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) cyc();
        rst = 1'b1;
        smp();
        put(32'd0); chk("rst_mid_busy_md_busy", {31'd0, md_busy_out});
        cyc();
        rst = 1'b0;
        smp();
        put(32'd0); chk("after_rst_md_busy", {31'd0, md_busy_out});
        cyc();
        drv_op(1'b1, OP_MFHI, 32'd0, 32'd0);
        smp();
        put(32'd0); chk("after_rst_mfhi_stall", {31'd0, stall_out});
        put(32'd0); chk("after_rst_mfhi", alu_result_out);
        cyc();
        drv_op(1'b1, OP_MFLO, 32'd0, 32'd0);
        smp();
        put(32'd0); chk("after_rst_mflo", alu_result_out);
        cyc();

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
